// File: rtl/bitwise_logic_pipe.sv
// W-bit bitwise logic unit with valid/ready on both sides and a two-entry
// output buffer (OUT plus SKID) so in_ready never depends on out_ready.
module bitwise_logic_pipe #(
    parameter int unsigned W         = 8,
    parameter bit          REG_FLAGS = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [2:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         zero,
    output logic         parity
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    typedef struct packed {
        logic [W-1:0] res;
        logic         zero;
        logic         parity;
    } entry_t;

    state_e state_q, state_d;
    entry_t out_q, out_d;
    entry_t skid_q, skid_d;
    logic   out_valid_q, out_valid_d;
    logic   in_ready_q, in_ready_d;

    logic [W-1:0] calc_res;
    entry_t       new_e;
    logic         accept;
    logic         drain;

    always_comb begin
        calc_res = '0;
        case (op)
            3'd0: calc_res = ~a;
            3'd1: calc_res = a & b;
            3'd2: calc_res = a | b;
            3'd3: calc_res = a ^ b;
            3'd4: calc_res = ~(a & b);
            3'd5: calc_res = ~(a | b);
            3'd6: calc_res = ~(a ^ b);
            3'd7: calc_res = a;
            default: calc_res = '0;
        endcase
        new_e.res    = calc_res;
        new_e.zero   = REG_FLAGS ? (calc_res == '0) : 1'b0;
        new_e.parity = REG_FLAGS ? (^calc_res)      : 1'b0;
    end

    assign accept = in_valid & in_ready_q;
    assign drain  = out_valid_q & out_ready;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    out_d   = new_e;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    out_d = new_e;
                end else if (accept) begin
                    skid_d  = new_e;
                    state_d = FULL;
                end else if (drain) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (drain) begin
                    out_d   = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        // Handshake outputs are registered from the next state so they never
        // form a combinational path from out_ready to in_ready.
        out_valid_d = (state_d != EMPTY);
        in_ready_d  = (state_d != FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= EMPTY;
            out_q       <= '0;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            out_q       <= out_d;
            skid_q      <= skid_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = out_q.res;
    assign zero      = out_q.zero;
    assign parity    = out_q.parity;

endmodule

// File: tb/tb_bitwise_logic_pipe.sv
// Scoreboard bench for bitwise_logic_pipe: the driver queues expected
// {result, zero, parity} on acceptance, a monitor pops on each output transfer.
module tb_bitwise_logic_pipe;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       zero;
    logic       parity;

    int tests;
    int fails;
    logic [9:0] sb[$];
    bit rand_done;

    bitwise_logic_pipe #(.W(8), .REG_FLAGS(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .parity    (parity)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] mk(input logic [7:0] r);
        logic z;
        logic p;
        z = (r == 8'h00);
        p = 1'b0;
        for (int i = 0; i < 8; i++) p = p ^ r[i];
        return {r, z, p};
    endfunction

    function automatic logic [7:0] model(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            case (o)
                3'd0: r[i] = !x[i];
                3'd1: r[i] = x[i] && y[i];
                3'd2: r[i] = x[i] || y[i];
                3'd3: r[i] = x[i] != y[i];
                3'd4: r[i] = !(x[i] && y[i]);
                3'd5: r[i] = !(x[i] || y[i]);
                3'd6: r[i] = x[i] == y[i];
                default: r[i] = x[i];
            endcase
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    // Monitor: an output transfer seen at the falling edge completes at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_output: got %h required none", {result, zero, parity});
            end else begin
                check("scoreboard", {result, zero, parity}, sb.pop_front());
            end
        end
    end

    task automatic send(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y, input logic [9:0] exp);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            sb.push_back(exp);
        end else begin
            tests++;
            fails++;
            $display("FAIL accept_timeout: got in_ready=0 required 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 500; n++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL drain_timeout: got %0d pending required 0", sb.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] ro;
        logic [7:0] ra;
        logic [7:0] rb;
        logic [7:0] sweep [8];
        tests = 0;
        fails = 0;
        rand_done = 1'b0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        op = 3'd0;
        a = 8'h00;
        b = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", {out_valid, in_ready, result, zero, parity}, 10'b01_0000_0000 << 2 >> 2);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Op sweep with a=A5, b=0F, each result visible one cycle after accept
        out_ready = 1'b1;
        sweep = '{8'h5A, 8'h05, 8'hAF, 8'hAA, 8'hFA, 8'h50, 8'h55, 8'hA5};
        for (int i = 0; i < 8; i++) begin
            send(3'(i), 8'hA5, 8'h0F, {sweep[i], 1'b0, 1'b0});
            check("sweep_latency", {7'd0, out_valid, result[0], parity}, {7'd0, 1'b1, sweep[i][0], 1'b0});
        end
        wait_drain();

        // Zero flag
        send(3'd3, 8'h3C, 8'h3C, {8'h00, 1'b1, 1'b0});
        send(3'd0, 8'hFF, 8'h00, {8'h00, 1'b1, 1'b0});
        wait_drain();

        // Backpressure: two accepted, third waits for in_ready to return
        out_ready = 1'b0;
        send(3'd1, 8'h12, 8'h34, {8'h10, 1'b0, 1'b1});
        send(3'd2, 8'h12, 8'h34, {8'h36, 1'b0, 1'b0});
        check("in_ready_full", {9'd0, in_ready}, 10'd0);
        fork
            send(3'd3, 8'h12, 8'h34, {8'h26, 1'b0, 1'b1});
            begin
                repeat (3) @(posedge clk);
                #1;
                check("in_ready_held", {9'd0, in_ready}, 10'd0);
                check("out_held", {result, zero, parity}, {8'h10, 1'b0, 1'b1});
                out_ready = 1'b1;
            end
        join
        wait_drain();

        // Stall stability with changing inputs and in_valid low
        out_ready = 1'b0;
        send(3'd6, 8'hF0, 8'hCC, {8'hC3, 1'b0, 1'b0});
        for (int i = 0; i < 5; i++) begin
            op = 3'(i + 1);
            a = 8'(i * 37);
            b = 8'(i * 91 + 5);
            @(negedge clk);
            check("stall_stable", {result, zero, parity}, {8'hC3, 1'b0, 1'b0});
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        wait_drain();

        // Asynchronous reset while FULL discards held results
        out_ready = 1'b0;
        send(3'd7, 8'h81, 8'h00, {8'h81, 1'b0, 1'b0});
        send(3'd4, 8'hFF, 8'hFF, {8'h00, 1'b1, 1'b0});
        check("full_before_reset", {8'd0, in_ready, out_valid}, 10'b01);
        #3;
        rst_n = 1'b0;
        #1;
        check("reset_midstream", {out_valid, in_ready, result}, {1'b0, 1'b1, 8'h00});
        check("reset_flags", {8'd0, zero, parity}, 10'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_reset_idle", {9'd0, out_valid}, 10'd0);
        @(posedge clk);
        #1;

        // Random in_valid gaps and out_ready toggling against the reference model
        fork
            begin
                for (int k = 0; k < 1000; k++) begin
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                    ro = 3'($urandom_range(0, 7));
                    ra = 8'($urandom);
                    rb = 8'($urandom);
                    send(ro, ra, rb, mk(model(ro, ra, rb)));
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 99) < 60);
                end
            end
        join
        out_ready = 1'b1;
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
